tmr_voter: RTL and testbench
============================

# tmr_voter

Registered triple-modular-redundancy voter that recombines the three replicated copies of a datapath word. It performs a bitwise 2-of-3 majority, counts per-lane disagreements, retires a lane after persistent disagreement, and falls back to dual-lane comparison and then to a halt. It sits at the merge point of a triplicated FIR stage and feeds the next non-redundant stage.

## Interface
- WIDTH, 1: data word width, ≥1
- CNT_WIDTH, 8: width of each per-lane error counter, ≥1
- FAULT_LIMIT, 4: consecutive disagreeing valid cycles that retire a lane or halt, ≥1
- clk  input  1  clock; all state changes on its rising edge
- rst_n  input  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low
- inA, inB, inC  input  WIDTH each  the three replicated lane words
- in_valid  input  1  the lane words are valid this cycle
- err_clr  input  1  synchronous clear of state, lane_fail, all counters
- out  output  WIDTH  voted word, registered
- out_valid  output  1  out is valid
- uncorr  output  1  single-cycle pulse aligned with out: surviving lanes disagreed in DUAL
- lane_fail  output  3  sticky retired-lane flags; bit0=A, bit1=B, bit2=C
- err_cnt_a, err_cnt_b, err_cnt_c  output  CNT_WIDTH each  saturating disagreement counts
- state  output  2  0=VOTE3, 1=DUAL, 2=HALT; 3 unused

## Operation
- Reset values: out=0, out_valid=0, uncorr=0, lane_fail=0, all err_cnt=0, state=VOTE3, internal consecutive counters=0.
- VOTE3 state:
  - out = (A&B)|(B&C)|(A&C), applied per bit.
  - Lane X disagrees when in_valid=1 and X≠out_word in any bit.
  - On each disagreeing valid cycle: err_cnt_X increments, saturating at 2^CNT_WIDTH−1, and consec_X increments.
  - On an agreeing valid cycle, consec_X clears to 0. Invalid cycles leave all counters unchanged.
  - When exactly one consec_X reaches FAULT_LIMIT: set lane_fail[X] and go to DUAL. If two or more reach it in the same cycle: set those bits and go to HALT.
- DUAL state (one lane retired):
  - Compare the two surviving lanes.
  - Equal: out = survivor value, uncorr=0, consec_d clears.
  - Unequal on a valid cycle: out holds its previous value, out_valid=1, uncorr=1, both survivors' err_cnt increment (saturating), consec_d increments.
  - When consec_d reaches FAULT_LIMIT, go to HALT.
  - Retired lane counters are frozen.
- HALT state: out holds its last value; out_valid=0; uncorr=0; inputs ignored; counters frozen. The block leaves HALT only on err_clr or reset.
- err_clr=1: state goes to VOTE3, and lane_fail, err_cnt_*, consec_* and consec_d all clear on the same edge. That cycle's out, out_valid and uncorr are still computed using the pre-clear state. Any counter or state updates from that cycle are discarded.
- Reset asserted mid-operation forces the reset values immediately, without waiting for a clock edge.

## Timing
- Latency is 1 cycle: inputs sampled at edge k appear on out, out_valid and uncorr after edge k.
- out_valid is in_valid delayed by 1 cycle, except it is 0 in HALT.
- lane_fail, state and err_cnt_* update on the same edge that registers the triggering word.
- The transition word itself is voted in the old state. The next word uses the new state.
- No backpressure; one word is accepted per cycle.

## Test plan
- WIDTH=8. After reset, drive A=B=C=0x5A with valid for 3 cycles. Required: out=0x5A, out_valid=1 one cycle later; all err_cnt=0; state=0.
- WIDTH=8. Drive A=0x00, B=C=0xFF with valid for 3 cycles, then an agreeing cycle, then 4 more cycles with A=0x00. Required: out=0xFF throughout; err_cnt_a=7; lane_fail=001 and state=1 set on the 7th disagreement edge, not the 3rd.
- In DUAL with A retired, drive B=0x11, C=0x22 for 4 valid cycles. Required: out holds its last value; uncorr=1 each cycle; state=2 after the 4th cycle; out_valid=0 afterwards.
- WIDTH=2. Make A differ in bit0 and B differ in bit1 for 4 cycles. Required: lane_fail=011 and state=2 on the same edge.
- CNT_WIDTH=2. Hold lane C disagreeing for 6 cycles with FAULT_LIMIT=10. Required: err_cnt_c saturates at 3.
- In HALT, pulse err_clr while in_valid=1. Required: next cycle state=0, lane_fail=0, all counters 0, and out_valid=0 for the clear cycle. Assert rst_n low mid-stream: outputs go to 0 before the next clock edge.

Source files
------------

// File: rtl/tmr_voter.sv
// Registered TMR voter: bitwise 2-of-3 majority with per-lane fault tracking,
// degradation to dual-lane comparison after one lane retires, and a halt state.
module tmr_voter #(
    parameter int unsigned WIDTH       = 1,
    parameter int unsigned CNT_WIDTH   = 8,
    parameter int unsigned FAULT_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     inA,
    input  logic [WIDTH-1:0]     inB,
    input  logic [WIDTH-1:0]     inC,
    input  logic                 in_valid,
    input  logic                 err_clr,
    output logic [WIDTH-1:0]     out,
    output logic                 out_valid,
    output logic                 uncorr,
    output logic [2:0]           lane_fail,
    output logic [CNT_WIDTH-1:0] err_cnt_a,
    output logic [CNT_WIDTH-1:0] err_cnt_b,
    output logic [CNT_WIDTH-1:0] err_cnt_c,
    output logic [1:0]           state
);

    localparam int unsigned CW = $clog2(FAULT_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(FAULT_LIMIT);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    localparam logic [1:0] S_VOTE3 = 2'd0;
    localparam logic [1:0] S_DUAL  = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;

    logic [WIDTH-1:0]     lane [3];
    logic [WIDTH-1:0]     maj;
    logic [WIDTH-1:0]     surv0;
    logic [WIDTH-1:0]     surv1;
    logic [2:0]           hits;

    logic [CNT_WIDTH-1:0] cnt_q [3];
    logic [CNT_WIDTH-1:0] cnt_d [3];
    logic [CW-1:0]        con_q [3];
    logic [CW-1:0]        con_d [3];
    logic [CW-1:0]        cd_q;
    logic [CW-1:0]        cd_d;

    logic [1:0]           state_nxt;
    logic [2:0]           fail_nxt;
    logic [WIDTH-1:0]     out_nxt;
    logic                 ov_nxt;
    logic                 unc_nxt;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_WIDTH'(1);
    endfunction

    assign err_cnt_a = cnt_q[0];
    assign err_cnt_b = cnt_q[1];
    assign err_cnt_c = cnt_q[2];

    always_comb begin
        lane[0] = inA;
        lane[1] = inB;
        lane[2] = inC;
    end

    assign maj = (inA & inB) | (inB & inC) | (inA & inC);

    // The two lanes still in service once one has been retired
    always_comb begin
        surv0 = inA;
        surv1 = inB;
        case (lane_fail)
            3'b001:  begin surv0 = inB; surv1 = inC; end
            3'b010:  begin surv0 = inA; surv1 = inC; end
            default: begin surv0 = inA; surv1 = inB; end
        endcase
    end

    // Next-state and registered-output computation
    always_comb begin
        state_nxt = state;
        fail_nxt  = lane_fail;
        out_nxt   = out;
        ov_nxt    = 1'b0;
        unc_nxt   = 1'b0;
        cnt_d     = cnt_q;
        con_d     = con_q;
        cd_d      = cd_q;
        hits      = 3'b000;

        case (state)
            S_VOTE3: begin
                ov_nxt = in_valid;
                if (in_valid) begin
                    out_nxt = maj;
                    for (int i = 0; i < 3; i++) begin
                        if (lane[i] != maj) begin
                            cnt_d[i] = sat_inc(cnt_q[i]);
                            con_d[i] = con_q[i] + CW'(1);
                            hits[i]  = (con_d[i] == LIMIT);
                        end else begin
                            con_d[i] = '0;
                        end
                    end
                    if (hits != 3'b000) begin
                        fail_nxt  = lane_fail | hits;
                        // A single retiring lane degrades; simultaneous ones halt
                        state_nxt = ((hits & (hits - 3'd1)) == 3'b000) ? S_DUAL : S_HALT;
                    end
                end
            end
            S_DUAL: begin
                ov_nxt = in_valid;
                if (in_valid) begin
                    if (surv0 == surv1) begin
                        out_nxt = surv0;
                        cd_d    = '0;
                    end else begin
                        unc_nxt = 1'b1;
                        for (int i = 0; i < 3; i++) begin
                            if (!lane_fail[i]) begin
                                cnt_d[i] = sat_inc(cnt_q[i]);
                            end
                        end
                        cd_d = cd_q + CW'(1);
                        if (cd_d == LIMIT) begin
                            state_nxt = S_HALT;
                        end
                    end
                end
            end
            S_HALT: begin
                state_nxt = S_HALT;
            end
            default: begin
                state_nxt = S_HALT;
            end
        endcase

        // Clear discards this cycle's bookkeeping but not its output word
        if (err_clr) begin
            state_nxt = S_VOTE3;
            fail_nxt  = 3'b000;
            cd_d      = '0;
            for (int i = 0; i < 3; i++) begin
                cnt_d[i] = '0;
                con_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_VOTE3;
            lane_fail <= 3'b000;
            out       <= '0;
            out_valid <= 1'b0;
            uncorr    <= 1'b0;
            cd_q      <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
                con_q[i] <= '0;
            end
        end else begin
            state     <= state_nxt;
            lane_fail <= fail_nxt;
            out       <= out_nxt;
            out_valid <= ov_nxt;
            uncorr    <= unc_nxt;
            cd_q      <= cd_d;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_d[i];
                con_q[i] <= con_d[i];
            end
        end
    end

endmodule

// File: tb/tb_tmr_voter.sv
// Self-checking bench for tmr_voter: directed scenarios plus randomized traffic
// against a behavioural model of the voting and lane-retirement rules.
module tb_tmr_voter;

    localparam int W    = 8;
    localparam int CNTW = 3;
    localparam int FL   = 4;
    localparam int CMAX = (1 << CNTW) - 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [W-1:0]    a, b, c;
    logic            v, clr;
    logic [W-1:0]    out;
    logic            out_valid, uncorr;
    logic [2:0]      lane_fail;
    logic [CNTW-1:0] err_cnt_a, err_cnt_b, err_cnt_c;
    logic [1:0]      state;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int        m_mode;
    logic [W-1:0] m_out;
    bit        m_ov, m_unc;
    bit [2:0]  m_fail;
    int        m_cnt [3];
    int        m_con [3];
    int        m_cd;

    always #5 clk = ~clk;

    tmr_voter #(.WIDTH(W), .CNT_WIDTH(CNTW), .FAULT_LIMIT(FL)) dut (
        .clk(clk), .rst_n(rst_n),
        .inA(a), .inB(b), .inC(c),
        .in_valid(v), .err_clr(clr),
        .out(out), .out_valid(out_valid), .uncorr(uncorr),
        .lane_fail(lane_fail),
        .err_cnt_a(err_cnt_a), .err_cnt_b(err_cnt_b), .err_cnt_c(err_cnt_c),
        .state(state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] majority(input logic [W-1:0] x, y, z);
        logic [W-1:0] r;
        int votes;
        for (int k = 0; k < W; k++) begin
            votes = int'(x[k]) + int'(y[k]) + int'(z[k]);
            r[k] = (votes >= 2);
        end
        return r;
    endfunction

    function automatic void model_reset();
        m_mode = 0; m_out = '0; m_ov = 0; m_unc = 0; m_fail = 3'b000; m_cd = 0;
        for (int i = 0; i < 3; i++) begin m_cnt[i] = 0; m_con[i] = 0; end
    endfunction

    function automatic void model_step(input logic [W-1:0] ia, ib, ic, input bit iv, iclr);
        logic [W-1:0] w [3];
        logic [W-1:0] mj;
        int nhit, s0, s1;
        w[0] = ia; w[1] = ib; w[2] = ic;
        m_ov = 0; m_unc = 0;
        if (m_mode == 0) begin
            m_ov = iv;
            if (iv) begin
                mj = majority(ia, ib, ic);
                m_out = mj;
                nhit = 0;
                for (int i = 0; i < 3; i++) begin
                    if (w[i] != mj) begin
                        m_cnt[i] = (m_cnt[i] < CMAX) ? m_cnt[i] + 1 : CMAX;
                        m_con[i]++;
                        if (m_con[i] == FL) begin m_fail[i] = 1'b1; nhit++; end
                    end else begin
                        m_con[i] = 0;
                    end
                end
                if (nhit == 1) m_mode = 1;
                else if (nhit > 1) m_mode = 2;
            end
        end else if (m_mode == 1) begin
            s0 = -1; s1 = -1;
            for (int i = 0; i < 3; i++) begin
                if (!m_fail[i]) begin
                    if (s0 < 0) s0 = i; else s1 = i;
                end
            end
            m_ov = iv;
            if (iv) begin
                if (w[s0] == w[s1]) begin
                    m_out = w[s0];
                    m_cd = 0;
                end else begin
                    m_unc = 1;
                    m_cnt[s0] = (m_cnt[s0] < CMAX) ? m_cnt[s0] + 1 : CMAX;
                    m_cnt[s1] = (m_cnt[s1] < CMAX) ? m_cnt[s1] + 1 : CMAX;
                    m_cd++;
                    if (m_cd == FL) m_mode = 2;
                end
            end
        end
        if (iclr) begin
            m_mode = 0; m_fail = 3'b000; m_cd = 0;
            for (int i = 0; i < 3; i++) begin m_cnt[i] = 0; m_con[i] = 0; end
        end
    endfunction

    task automatic compare_all(input string tag);
        if (m_ov || m_mode == 2) check({tag, "_out"}, 32'(out), 32'(m_out));
        check({tag, "_out_valid"}, 32'(out_valid), 32'(m_ov));
        check({tag, "_uncorr"}, 32'(uncorr), 32'(m_unc));
        check({tag, "_lane_fail"}, 32'(lane_fail), 32'(m_fail));
        check({tag, "_state"}, 32'(state), 32'(m_mode));
        check({tag, "_cnt_a"}, 32'(err_cnt_a), 32'(m_cnt[0]));
        check({tag, "_cnt_b"}, 32'(err_cnt_b), 32'(m_cnt[1]));
        check({tag, "_cnt_c"}, 32'(err_cnt_c), 32'(m_cnt[2]));
    endtask

    task automatic cycle(input string tag, input logic [W-1:0] ia, ib, ic, input logic iv, iclr);
        a = ia; b = ib; c = ic; v = iv; clr = iclr;
        model_step(ia, ib, ic, iv, iclr);
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic async_reset();
        rst_n = 1'b0;
        #1;
        check("rst_async_out", 32'(out), 32'h0);
        check("rst_async_out_valid", 32'(out_valid), 32'h0);
        check("rst_async_state", 32'(state), 32'h0);
        check("rst_async_lane_fail", 32'(lane_fail), 32'h0);
        check("rst_async_cnts", 32'({err_cnt_a, err_cnt_b, err_cnt_c}), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [W-1:0] base, la, lb, lc;
        rst_n = 1'b0; a = '0; b = '0; c = '0; v = 1'b0; clr = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all("reset");
        rst_n = 1'b1;

        // All lanes agree
        repeat (3) cycle("agree", 8'h5A, 8'h5A, 8'h5A, 1'b1, 1'b0);
        check("agree_out_dir", 32'(out), 32'h5A);

        // Lane A wrong: 3 misses, one agreement, then 4 more misses retire it
        repeat (3) cycle("a_bad", 8'h00, 8'hFF, 8'hFF, 1'b1, 1'b0);
        check("a_bad3_state_dir", 32'(state), 32'h0);
        cycle("a_ok", 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0);
        repeat (3) cycle("a_bad", 8'h00, 8'hFF, 8'hFF, 1'b1, 1'b0);
        check("a_bad6_fail_dir", 32'(lane_fail), 32'h0);
        cycle("a_bad", 8'h00, 8'hFF, 8'hFF, 1'b1, 1'b0);
        check("a_retire_cnt_dir", 32'(err_cnt_a), 32'h7);
        check("a_retire_fail_dir", 32'(lane_fail), 32'h1);
        check("a_retire_state_dir", 32'(state), 32'h1);
        check("a_retire_out_dir", 32'(out), 32'hFF);

        // Survivors B and C disagree in DUAL until halt
        repeat (4) cycle("dual_bad", 8'h00, 8'h11, 8'h22, 1'b1, 1'b0);
        check("dual_halt_state_dir", 32'(state), 32'h2);
        check("dual_hold_out_dir", 32'(out), 32'hFF);
        cycle("halt", 8'h33, 8'h33, 8'h33, 1'b1, 1'b0);
        check("halt_out_valid_dir", 32'(out_valid), 32'h0);

        // Clear while halted
        cycle("halt_clr", 8'h44, 8'h44, 8'h44, 1'b1, 1'b1);
        check("clr_out_valid_dir", 32'(out_valid), 32'h0);
        check("clr_state_dir", 32'(state), 32'h0);
        check("clr_cnt_a_dir", 32'(err_cnt_a), 32'h0);

        // Two lanes retire on the same edge
        repeat (4) cycle("dbl", 8'h5B, 8'h58, 8'h5A, 1'b1, 1'b0);
        check("dbl_fail_dir", 32'(lane_fail), 32'h3);
        check("dbl_state_dir", 32'(state), 32'h2);
        cycle("dbl_clr", 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);

        // Lane C counter saturation with intermittent agreement
        for (int r = 0; r < 3; r++) begin
            repeat (3) cycle("c_sat", 8'h0F, 8'h0F, 8'hF0, 1'b1, 1'b0);
            cycle("c_ok", 8'h0F, 8'h0F, 8'h0F, 1'b1, 1'b0);
        end
        check("c_sat_dir", 32'(err_cnt_c), 32'h7);
        check("c_sat_state_dir", 32'(state), 32'h0);

        // Invalid cycles leave counters untouched
        repeat (2) cycle("idle", 8'h01, 8'h02, 8'h04, 1'b0, 1'b0);

        // Randomized traffic with occasional clears and one async reset
        for (int n = 0; n < 600; n++) begin
            if (n == 300) async_reset();
            base = W'($urandom);
            la = base; lb = base; lc = base;
            if ($urandom_range(0, 99) < 15) la = la ^ (W'(1) << $urandom_range(0, W - 1));
            if ($urandom_range(0, 99) < 15) lb = lb ^ (W'(1) << $urandom_range(0, W - 1));
            if ($urandom_range(0, 99) < 15) lc = lc ^ (W'(1) << $urandom_range(0, W - 1));
            cycle("rand", la, lb, lc, ($urandom_range(0, 9) != 0), ($urandom_range(0, 59) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
